// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and port enums for the memory port arbiter
package mem_arb;

    typedef enum logic [1:0] {IDLE, INST, DATA, DONE} arb_state_t;
    typedef enum logic {port_inst, port_data} port_t;

    localparam logic [3:0] INST_BYTE_ENABLE = 4'hF;

endpackage

// File: rtl/mem_arb_req_reg.sv
// rtl/mem_arb_req_reg.sv - registered downstream request: load, clear strobes, or hold
module mem_arb_req_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [31:0] address_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  byte_enable_in,
    output logic        read_out,
    output logic        write_out,
    output logic [31:0] address_out,
    output logic [31:0] wdata_out,
    output logic [3:0]  byte_enable_out
);

    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  byte_enable_q, byte_enable_d;

    always_comb begin
        read_d        = read_q;
        write_d       = write_q;
        address_d     = address_q;
        wdata_d       = wdata_q;
        byte_enable_d = byte_enable_q;
        if (load) begin
            read_d        = read_in;
            write_d       = write_in;
            address_d     = address_in;
            wdata_d       = wdata_in;
            byte_enable_d = byte_enable_in;
        end else if (clear) begin
            // address/data stay put; only the strobes drop
            read_d  = 1'b0;
            write_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            address_q     <= '0;
            wdata_q       <= '0;
            byte_enable_q <= '0;
        end else begin
            read_q        <= read_d;
            write_q       <= write_d;
            address_q     <= address_d;
            wdata_q       <= wdata_d;
            byte_enable_q <= byte_enable_d;
        end
    end

    assign read_out        = read_q;
    assign write_out       = write_q;
    assign address_out     = address_q;
    assign wdata_out       = wdata_q;
    assign byte_enable_out = byte_enable_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (inst/data) to one memory arbiter; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
    import mem_arb::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_mem_read,
    input  logic [31:0] inst_mem_address,
    output logic [31:0] inst_mem_rdata,
    output logic        inst_mem_resp,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [3:0]  data_mem_byte_enable,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t  state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        inst_resp_q, inst_resp_d;
    logic        data_resp_q, data_resp_d;
    port_t       grant_port;
    logic        load, clear;
    logic        ld_read, ld_write;
    logic [31:0] ld_address, ld_wdata;
    logic [3:0]  ld_byte_enable;
    logic        data_pend, inst_pend;

`ifdef MEM_ARB_RR_EN
    port_t last_served_q, last_served_d;
`endif

    assign data_pend = data_mem_read | data_mem_write;
    assign inst_pend = inst_mem_read;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        inst_resp_d = 1'b0;
        data_resp_d = 1'b0;
        load        = 1'b0;
        clear       = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (data_pend && inst_pend)
            grant_port = (last_served_q == port_inst) ? port_data : port_inst;
        else
            grant_port = data_pend ? port_data : port_inst;
`else
        grant_port = data_pend ? port_data : port_inst;
`endif
        case (state_q)
            IDLE: begin
                if (data_pend || inst_pend) begin
                    load    = 1'b1;
                    state_d = (grant_port == port_data) ? DATA : INST;
                end
            end
            INST, DATA: begin
                if (mem_resp) begin
                    clear       = 1'b1;
                    hold_d      = mem_rdata;
                    inst_resp_d = (state_q == INST);
                    data_resp_d = (state_q == DATA);
                    state_d     = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // a simultaneous read+write on the data port is issued as a write
    always_comb begin
        if (grant_port == port_data) begin
            ld_read        = data_mem_read & ~data_mem_write;
            ld_write       = data_mem_write;
            ld_address     = data_mem_address;
            ld_wdata       = data_mem_wdata;
            ld_byte_enable = data_mem_byte_enable;
        end else begin
            ld_read        = 1'b1;
            ld_write       = 1'b0;
            ld_address     = inst_mem_address;
            ld_wdata       = '0;
            ld_byte_enable = INST_BYTE_ENABLE;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_served_d = load ? grant_port : last_served_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_served_q <= port_inst;
        else     last_served_q <= last_served_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            inst_resp_q <= 1'b0;
            data_resp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            inst_resp_q <= inst_resp_d;
            data_resp_q <= data_resp_d;
        end
    end

    mem_arb_req_reg u_req_reg (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .clear           (clear),
        .read_in         (ld_read),
        .write_in        (ld_write),
        .address_in      (ld_address),
        .wdata_in        (ld_wdata),
        .byte_enable_in  (ld_byte_enable),
        .read_out        (mem_read),
        .write_out       (mem_write),
        .address_out     (mem_address),
        .wdata_out       (mem_wdata),
        .byte_enable_out (mem_byte_enable)
    );

    assign inst_mem_rdata = hold_q;
    assign data_mem_rdata = hold_q;
    assign inst_mem_resp  = inst_resp_q;
    assign data_mem_resp  = data_resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level check of mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_mem_read;
    logic [31:0] inst_mem_address;
    logic [31:0] inst_mem_rdata;
    logic        inst_mem_resp;
    logic        data_mem_read;
    logic        data_mem_write;
    logic [3:0]  data_mem_byte_enable;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int tests = 0;
    int fails = 0;
    int last_served = 0;      // 0 = inst, 1 = data
    logic [31:0] last_rd = '0;

    mem_port_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_mem_read        (inst_mem_read),
        .inst_mem_address     (inst_mem_address),
        .inst_mem_rdata       (inst_mem_rdata),
        .inst_mem_resp        (inst_mem_resp),
        .data_mem_read        (data_mem_read),
        .data_mem_write       (data_mem_write),
        .data_mem_byte_enable (data_mem_byte_enable),
        .data_mem_address     (data_mem_address),
        .data_mem_wdata       (data_mem_wdata),
        .data_mem_rdata       (data_mem_rdata),
        .data_mem_resp        (data_mem_resp),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_address          (mem_address),
        .mem_wdata            (mem_wdata),
        .mem_byte_enable      (mem_byte_enable),
        .mem_rdata            (mem_rdata),
        .mem_resp             (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int pick_winner(input bit ip, input bit dp);
        if (ip && dp) begin
`ifdef MEM_ARB_RR_EN
            return (last_served == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return dp ? 1 : 0;
    endfunction

    task automatic idle_inputs();
        inst_mem_read  = 1'b0;
        data_mem_read  = 1'b0;
        data_mem_write = 1'b0;
        mem_resp       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd"},   {31'b0, mem_read}, 32'd0);
        check_eq({tag, "_wr"},   {31'b0, mem_write}, 32'd0);
        check_eq({tag, "_addr"}, mem_address, 32'd0);
        check_eq({tag, "_wd"},   mem_wdata, 32'd0);
        check_eq({tag, "_be"},   {28'b0, mem_byte_enable}, 32'd0);
        check_eq({tag, "_hold"}, inst_mem_rdata, 32'd0);
        check_eq({tag, "_iresp"}, {31'b0, inst_mem_resp}, 32'd0);
        check_eq({tag, "_dresp"}, {31'b0, data_mem_resp}, 32'd0);
    endtask

    // One round: present the chosen requests together, serve every grant
    // with a memory that answers after `lat` extra cycles.
    task automatic run_round(input bit want_inst, input bit want_data,
                             input logic [31:0] ia, input logic [31:0] da,
                             input logic [31:0] wd, input logic [3:0] be,
                             input bit drd, input bit dwr, input int lat,
                             input logic [31:0] rdv, input bit poke);
        bit ip, dp;
        int w, waited, n;
        logic [31:0] exp_addr, rd;
        @(negedge clk);
        inst_mem_read        = want_inst;
        inst_mem_address     = ia;
        data_mem_read        = want_data & drd;
        data_mem_write       = want_data & dwr;
        data_mem_address     = da;
        data_mem_wdata       = wd;
        data_mem_byte_enable = be;
        ip = want_inst;
        dp = want_data & (drd | dwr);
        n  = 0;
        while (ip || dp) begin
            w = pick_winner(ip, dp);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!(mem_read || mem_write) && waited < 8);
            if (!(mem_read || mem_write)) begin
                check_eq("strobe_timeout", 32'd0, 32'd1);
                idle_inputs();
                return;
            end
            check_eq("grant_latency", waited, 32'd1);
            exp_addr = (w == 1) ? da : ia;
            check_eq("mem_read",  {31'b0, mem_read},  (w == 1) ? {31'b0, drd & ~dwr} : 32'd1);
            check_eq("mem_write", {31'b0, mem_write}, (w == 1) ? {31'b0, dwr} : 32'd0);
            check_eq("mem_address", mem_address, exp_addr);
            check_eq("mem_be", {28'b0, mem_byte_enable}, (w == 1) ? {28'b0, be} : 32'hF);
            if (w == 1) check_eq("mem_wdata", mem_wdata, wd);
            for (int k = 0; k < lat; k++) begin
                if (poke) begin
                    if (w == 1) data_mem_address = da ^ 32'hC0;
                    else        inst_mem_address = ia ^ 32'hC0;
                end
                @(negedge clk);
                check_eq("addr_hold", mem_address, exp_addr);
                check_eq("strobe_hold", {30'b0, mem_read, mem_write},
                         (w == 1) ? {30'b0, drd & ~dwr, dwr} : 32'd2);
            end
            rd = (n == 0) ? rdv : ~rdv;
            mem_resp  = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            mem_resp  = 1'b0;
            mem_rdata = $urandom;
            check_eq("inst_resp", {31'b0, inst_mem_resp}, (w == 0) ? 32'd1 : 32'd0);
            check_eq("data_resp", {31'b0, data_mem_resp}, (w == 1) ? 32'd1 : 32'd0);
            check_eq("inst_rdata", inst_mem_rdata, rd);
            check_eq("data_rdata", data_mem_rdata, rd);
            check_eq("strobe_clr", {30'b0, mem_read, mem_write}, 32'd0);
            if (w == 1) begin
                data_mem_read  = 1'b0;
                data_mem_write = 1'b0;
                dp = 1'b0;
            end else begin
                inst_mem_read = 1'b0;
                ip = 1'b0;
            end
            last_served = w;
            last_rd     = rd;
            n++;
            @(negedge clk);
            check_eq("resp_pulse", {30'b0, inst_mem_resp, data_mem_resp}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        inst_mem_address     = '0;
        data_mem_address     = '0;
        data_mem_wdata       = '0;
        data_mem_byte_enable = '0;
        mem_rdata            = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_round(1, 0, 32'h0000_0040, 32'h0, 32'h0, 4'h0, 0, 0, 3, 32'h0000_0013, 0);
        run_round(0, 1, 32'h0, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 0, 1, 1, 32'h0, 0);
        run_round(1, 1, 32'h0000_0100, 32'h2000_0000, 32'h1234_5678, 4'hC, 1, 0, 0, 32'hCAFE_0001, 0);
        run_round(1, 0, 32'h0000_0040, 32'h0, 32'h0, 4'h0, 0, 0, 3, 32'h0000_0077, 1);
        run_round(0, 1, 32'h0, 32'h3000_0010, 32'hA5A5_A5A5, 4'h6, 1, 1, 2, 32'h0, 0);

        // stray mem_resp while idle must be ignored
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        mem_resp = 1'b0;
        check_eq("idle_resp", {30'b0, inst_mem_resp, data_mem_resp}, 32'd0);
        check_eq("idle_strobe", {30'b0, mem_read, mem_write}, 32'd0);
        check_eq("idle_hold", inst_mem_rdata, last_rd);

        for (int r = 0; r < 60; r++) begin
            bit wi, wdt, rr, ww;
            wi  = 1'($urandom);
            wdt = 1'($urandom);
            rr  = 1'($urandom);
            ww  = 1'($urandom);
            if (!rr && !ww) rr = 1'b1;
            run_round(wi, wdt, $urandom, $urandom, $urandom, 4'($urandom),
                      rr, ww, int'($urandom_range(0, 3)), $urandom, 1'($urandom));
        end

        // reset during DATA, memory answers one cycle later
        @(negedge clk);
        data_mem_write       = 1'b1;
        data_mem_address     = 32'h4000_0008;
        data_mem_wdata       = 32'h0BAD_F00D;
        data_mem_byte_enable = 4'hF;
        @(negedge clk);
        check_eq("abort_strobe", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        data_mem_write = 1'b0;
        mem_resp       = 1'b1;
        mem_rdata      = 32'h1111_2222;
        check_reset_outputs("abort");
        @(negedge clk);
        mem_resp = 1'b0;
        check_reset_outputs("late_resp");
        last_served = 0;

        run_round(1, 1, 32'h0000_0200, 32'h5000_0000, 32'h0, 4'h1, 1, 0, 1, 32'h0101_0101, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: none; address and data widths are fixed at 32 bits, byte enable at 4 bits.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inst_mem_read  in  1  instruction-port read request, held until inst_mem_resp.
REQ-005 inst_mem_address  in  32  instruction-port address.
REQ-006 inst_mem_rdata  out  32  instruction-port read data, valid while inst_mem_resp=1.
REQ-007 inst_mem_resp  out  1  one-cycle completion pulse, instruction port.
REQ-008 data_mem_read  in  1  data-port read request, held until data_mem_resp.
REQ-009 data_mem_write  in  1  data-port write request, held until data_mem_resp.
REQ-010 data_mem_byte_enable  in  4  data-port write byte mask.
REQ-011 data_mem_address  in  32  data-port address.
REQ-012 data_mem_wdata  in  32  data-port write data.
REQ-013 data_mem_rdata  out  32  data-port read data, valid while data_mem_resp=1.
REQ-014 data_mem_resp  out  1  one-cycle completion pulse, data port.
REQ-015 mem_read, mem_write  out  1 each  downstream request strobes, registered.
REQ-016 mem_address, mem_wdata  out  32 each  downstream address and write data, registered.
REQ-017 mem_byte_enable  out  4  downstream byte mask (4'hF for instruction reads), registered.
REQ-018 mem_rdata  in  32  downstream read data, sampled when mem_resp=1.
REQ-019 mem_resp  in  1  downstream completion, one cycle.

Function
REQ-020 FSM states SHALL be IDLE, INST, DATA, DONE.
REQ-021 In IDLE, request sampling: data pending = data_mem_read|data_mem_write; inst pending = inst_mem_read; only IDLE grants.
REQ-022 Arbitration (macro off): data port SHALL win when both pending.
REQ-023 On grant the block SHALL register address/wdata/byte_enable/read/write into mem_* outputs and enter INST or DATA; mem_* request strobes assert the cycle after grant.
REQ-024 In INST/DATA, mem_* outputs SHALL stay constant until mem_resp; changes on upstream inputs are ignored.
REQ-025 On mem_resp: mem_read/mem_write deassert next cycle; mem_rdata captured into a hold register; FSM enters DONE.
REQ-026 In DONE the granted port's resp SHALL be 1 for exactly one cycle with rdata from the hold register; FSM then returns to IDLE (no re-grant of the completing request).
REQ-027 Minimum latency: request at cycle 0, strobe at 1, mem_resp at 1 -> resp at cycle 2; next grant earliest cycle 3.
REQ-028 data_mem_read and data_mem_write both high SHALL be treated as a write.
REQ-029 mem_resp in IDLE or DONE SHALL be ignored.
REQ-030 inst_mem_rdata and data_mem_rdata SHALL both show the hold register; only resp distinguishes ownership.

Reset
REQ-031 rst SHALL force IDLE; mem_read, mem_write, inst_mem_resp, data_mem_resp = 0; mem_address, mem_wdata, hold register = 0; mem_byte_enable = 0; last-served = INST.
REQ-032 rst mid-transaction SHALL abort it with no resp pulse; a late mem_resp after reset is ignored per REQ-029.

Configuration
REQ-033 MEM_ARB_RR_EN defined: when both ports pending in IDLE, grant the port not served last (last-served flop updated at each grant); single pending port always granted.
REQ-034 MEM_ARB_RR_EN undefined: fixed data priority per REQ-022; last-served flop absent.

Structure
REQ-035 Package mem_arb SHALL hold typedef enum arb_state_t {IDLE, INST, DATA, DONE} and typedef enum port_t {port_inst, port_data}.
REQ-036 One sub-module mem_arb_req_reg SHALL implement the registered downstream request (load, clear, hold) used for both ports.

Verification
REQ-037 Inst read 0x0000_0040, mem_resp 3 cycles after strobe, mem_rdata 0x0000_0013 -> inst_mem_resp one cycle, rdata 0x0000_0013, mem_byte_enable 4'hF.
REQ-038 Data write 0x1000_0004, wdata 0xDEAD_BEEF, be 4'b0011 -> mem_write with identical values, data_mem_resp one pulse, inst_mem_resp stays 0.
REQ-039 Inst and data requests in same cycle, macro off -> data served first, then inst; with MEM_ARB_RR_EN after prior data grant -> inst first.
REQ-040 Upstream address changed from 0x40 to 0x80 during INST -> mem_address stays 0x40 until mem_resp.
REQ-041 rst asserted during DATA with mem_resp arriving next cycle -> no data_mem_resp, all outputs reset values, FSM IDLE.
